// File: rtl/imm_gen_pipe_if.sv
// Request/result bus for the decode-stage immediate generator.
// master drives requests and accepts results; slave is the generator itself.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
);
    logic             inValid;
    logic             inReady;
    logic [31:0]      instr;
    logic [2:0]       extOp;
    logic [TAG_W-1:0] inTag;
    logic             outValid;
    logic             outReady;
    logic [XLEN-1:0]  sOut;
    logic [TAG_W-1:0] outTag;
    logic             outErr;

    modport master (
        output inValid, instr, extOp, inTag, outReady,
        input  inReady, outValid, sOut, outTag, outErr
    );

    modport slave (
        input  inValid, instr, extOp, inTag, outReady,
        output inReady, outValid, sOut, outTag, outErr
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Immediate generator feeding a 2-entry result queue with valid/ready on both sides.
// Illegal format selectors produce a zero immediate flagged as an error and are counted.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_flush,
    imm_gen_pipe_if.slave bus,
    output logic [7:0]    o_errCnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             err;
    } entry_t;

    state_t     r_state;
    state_t     w_nextState;
    entry_t     r_head;
    entry_t     r_tail;
    entry_t     w_newEntry;
    logic       w_push;
    logic       w_pop;
    logic [7:0] r_errCnt;

    always_comb begin
        w_newEntry     = '0;
        w_newEntry.tag = bus.inTag;
        case (bus.extOp)
            3'b000: w_newEntry.imm = XLEN'($signed(bus.instr[31:20]));
            3'b001: w_newEntry.imm = XLEN'($signed({bus.instr[31:12], 12'b0}));
            3'b010: w_newEntry.imm = XLEN'($signed({bus.instr[31:25], bus.instr[11:7]}));
            3'b011: w_newEntry.imm = XLEN'($signed({bus.instr[31], bus.instr[7],
                                                    bus.instr[30:25], bus.instr[11:8], 1'b0}));
            3'b100: w_newEntry.imm = XLEN'($signed({bus.instr[31], bus.instr[19:12],
                                                    bus.instr[20], bus.instr[30:21], 1'b0}));
            3'b101: begin
                // RV64 shift amounts carry one extra bit
                if (XLEN == 64) w_newEntry.imm = XLEN'(bus.instr[25:20]);
                else            w_newEntry.imm = XLEN'(bus.instr[24:20]);
            end
            3'b110: w_newEntry.imm = XLEN'(bus.instr[19:15]);
            default: w_newEntry.err = 1'b1;
        endcase
    end

    assign w_push = bus.inValid && (r_state != FULL);
    assign w_pop  = (r_state != EMPTY) && bus.outReady;

    always_comb begin
        w_nextState = r_state;
        if (i_flush) begin
            w_nextState = EMPTY;
        end else begin
            case (r_state)
                EMPTY: if (w_push) w_nextState = ONE;
                ONE: begin
                    if (w_push && !w_pop)      w_nextState = FULL;
                    else if (w_pop && !w_push) w_nextState = EMPTY;
                end
                FULL:    if (w_pop) w_nextState = ONE;
                default: w_nextState = EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= EMPTY;
        else          r_state <= w_nextState;
    end

    // Entries left behind by a flush are never shown: OUT_VALID masks them
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_pop && r_state == FULL) r_head <= r_tail;
            if (w_push) begin
                if (r_state == EMPTY || w_pop) r_head <= w_newEntry;
                else                           r_tail <= w_newEntry;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_errCnt <= 8'd0;
        else if (w_push && bus.extOp == 3'b111 && r_errCnt != 8'hFF)
            r_errCnt <= r_errCnt + 8'd1;
    end

    assign bus.inReady  = (r_state != FULL);
    assign bus.outValid = (r_state != EMPTY);
    assign bus.sOut     = bus.outValid ? r_head.imm : '0;
    assign bus.outTag   = bus.outValid ? r_head.tag : '0;
    assign bus.outErr   = bus.outValid ? r_head.err : 1'b0;
    assign o_errCnt     = r_errCnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Drives an XLEN=32 and an XLEN=64 generator with identical traffic and
// compares both against a queue-based reference model.
module tb_imm_gen_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic [7:0] errCntA;
    logic [7:0] errCntB;

    int vectorCount = 0;
    int missCount   = 0;

    typedef struct {
        logic [63:0] imm32;
        logic [63:0] imm64;
        logic [3:0]  tag;
        logic        err;
    } expEntry_t;

    expEntry_t modelQ[$];
    int        modelErr = 0;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(4)) busA ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(4)) busB ();

    imm_gen_pipe #(.XLEN(32), .TAG_W(4)) dutA (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_flush  (flush),
        .bus      (busA.slave),
        .o_errCnt (errCntA)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(4)) dutB (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_flush  (flush),
        .bus      (busB.slave),
        .o_errCnt (errCntB)
    );

    function automatic longint signFix(longint f, int width);
        longint half = longint'(1) << (width - 1);
        return (f >= half) ? f - (longint'(1) << width) : f;
    endfunction

    // Reference immediates built as integers from the field layout
    function automatic logic [63:0] refImm(logic [31:0] ins, logic [2:0] op, int xlen);
        longint v;
        logic [63:0] r;
        case (op)
            3'd0: v = signFix(longint'(ins[31:20]), 12);
            3'd1: v = signFix(longint'(ins) & 64'hFFFFF000, 32);
            3'd2: v = signFix(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12);
            3'd3: v = signFix(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
                              + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
            3'd4: v = signFix(longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096
                              + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
            3'd5: v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
            3'd6: v = longint'(ins[19:15]);
            default: v = 0;
        endcase
        r = 64'(v);
        if (xlen == 32) r = {32'd0, r[31:0]};
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectorCount++;
        if (obs !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkState();
        logic [63:0] e32;
        logic [63:0] e64;
        logic [63:0] eTag;
        logic [63:0] eErr;
        e32 = 0; e64 = 0; eTag = 0; eErr = 0;
        if (modelQ.size() > 0) begin
            e32  = modelQ[0].imm32;
            e64  = modelQ[0].imm64;
            eTag = 64'(modelQ[0].tag);
            eErr = 64'(modelQ[0].err);
        end
        checkOutput("inReadyA",  64'(busA.inReady),  64'(modelQ.size() < 2));
        checkOutput("inReadyB",  64'(busB.inReady),  64'(modelQ.size() < 2));
        checkOutput("outValidA", 64'(busA.outValid), 64'(modelQ.size() > 0));
        checkOutput("outValidB", 64'(busB.outValid), 64'(modelQ.size() > 0));
        checkOutput("sOutA",     64'(busA.sOut),     e32);
        checkOutput("sOutB",     busB.sOut,          e64);
        checkOutput("outTagA",   64'(busA.outTag),   eTag);
        checkOutput("outTagB",   64'(busB.outTag),   eTag);
        checkOutput("outErrA",   64'(busA.outErr),   eErr);
        checkOutput("outErrB",   64'(busB.outErr),   eErr);
        checkOutput("errCntA",   64'(errCntA),       64'(modelErr));
        checkOutput("errCntB",   64'(errCntB),       64'(modelErr));
    endtask

    task automatic driveInputs(input logic v, input logic [31:0] ins, input logic [2:0] op,
                               input logic [3:0] tag, input logic outR, input logic fl);
        busA.inValid = v;  busB.inValid = v;
        busA.instr = ins;  busB.instr = ins;
        busA.extOp = op;   busB.extOp = op;
        busA.inTag = tag;  busB.inTag = tag;
        busA.outReady = outR;  busB.outReady = outR;
        flush = fl;
    endtask

    // One clock: drive at negedge, check, clock the DUT, advance the model
    task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [2:0] op,
                                 input logic [3:0] tag, input logic outR, input logic fl,
                                 output logic accepted);
        logic doPush;
        logic doPop;
        expEntry_t e;
        driveInputs(v, ins, op, tag, outR, fl);
        checkState();
        doPush = v && (modelQ.size() < 2);
        doPop  = outR && (modelQ.size() > 0);
        accepted = doPush;
        @(posedge clk);
        if (doPush && op == 3'd7 && modelErr < 255) modelErr++;
        if (fl) begin
            modelQ.delete();
        end else begin
            if (doPop) void'(modelQ.pop_front());
            if (doPush) begin
                e.imm32 = refImm(ins, op, 32);
                e.imm64 = refImm(ins, op, 64);
                e.tag   = tag;
                e.err   = (op == 3'd7);
                modelQ.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic idleDrain();
        logic acc;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'd0, 3'd0, 4'd0, 1'b1, 1'b0, acc);
    endtask

    initial begin
        logic        acc;
        logic        pendV;
        logic [31:0] pIns;
        logic [2:0]  pOp;
        logic [3:0]  pTag;
        logic        outR;
        logic        fl;

        rst_n = 1'b0;
        driveInputs(1'b0, 32'd0, 3'd0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checkState();
        checkOutput("rstSout", 64'(busA.sOut), 64'd0);
        rst_n = 1'b1;

        applyStimulus(1'b1, 32'hFFF00093, 3'd0, 4'd3, 1'b0, 1'b0, acc);
        checkOutput("iFmtValid", 64'(busA.outValid), 64'd1);
        checkOutput("iFmtSout",  64'(busA.sOut),     64'hFFFFFFFF);
        checkOutput("iFmtTag",   64'(busA.outTag),   64'd3);
        idleDrain();

        applyStimulus(1'b1, 32'hFE000EE3, 3'd3, 4'd4, 1'b0, 1'b0, acc);
        checkOutput("bFmtSout", 64'(busA.sOut), 64'hFFFFFFFC);
        idleDrain();

        applyStimulus(1'b1, 32'h800002B7, 3'd1, 4'd5, 1'b0, 1'b0, acc);
        checkOutput("uFmtSout64", busB.sOut, 64'hFFFFFFFF80000000);
        idleDrain();

        applyStimulus(1'b1, 32'h03F00013, 3'd5, 4'd6, 1'b0, 1'b0, acc);
        checkOutput("shamt64", busB.sOut,       64'h3F);
        checkOutput("shamt32", 64'(busA.sOut),  64'h1F);
        idleDrain();

        applyStimulus(1'b1, 32'h00100093, 3'd0, 4'd1, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 32'h00200093, 3'd0, 4'd2, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 32'h00300093, 3'd0, 4'd3, 1'b0, 1'b0, acc);
        checkOutput("bpTag3Held", 64'(acc),           64'd0);
        checkOutput("bpInReady",  64'(busA.inReady),  64'd0);
        checkOutput("bpHead1",    64'(busA.outTag),   64'd1);
        applyStimulus(1'b1, 32'h00300093, 3'd0, 4'd3, 1'b1, 1'b0, acc);
        checkOutput("bpHead2", 64'(busA.outTag), 64'd2);
        applyStimulus(1'b1, 32'h00300093, 3'd0, 4'd3, 1'b1, 1'b0, acc);
        checkOutput("bpHead3", 64'(busA.outTag), 64'd3);
        idleDrain();

        applyStimulus(1'b1, 32'h12345678, 3'd7, 4'd9, 1'b0, 1'b0, acc);
        checkOutput("illErr",    64'(busA.outErr), 64'd1);
        checkOutput("illSout",   busB.sOut,        64'd0);
        checkOutput("illErrCnt", 64'(errCntA),     64'd1);
        idleDrain();

        applyStimulus(1'b1, 32'h00500093, 3'd0, 4'd7, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 32'h00600093, 3'd0, 4'd8, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 32'h00700093, 3'd2, 4'd9, 1'b0, 1'b1, acc);
        checkOutput("flushValid", 64'(busA.outValid), 64'd0);
        checkOutput("flushReady", 64'(busA.inReady),  64'd1);
        checkOutput("flushErr",   64'(errCntA),       64'd1);
        applyStimulus(1'b1, 32'h00800093, 3'd0, 4'd1, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 32'hABCDEF01, 3'd7, 4'd2, 1'b0, 1'b1, acc);
        checkOutput("flushIllCnt", 64'(errCntA), 64'd2);
        idleDrain();

        for (int i = 0; i < 300; i++)
            applyStimulus(1'b1, $urandom, 3'd7, 4'($urandom), 1'b1, 1'b0, acc);
        checkOutput("errSat", 64'(errCntB), 64'd255);
        idleDrain();

        pendV = 1'b0;
        pIns = 0; pOp = 0; pTag = 0;
        for (int i = 0; i < 400; i++) begin
            if (!pendV) begin
                pendV = ($urandom_range(0, 3) != 0);
                pIns  = $urandom;
                pOp   = 3'($urandom_range(0, 7));
                pTag  = 4'($urandom);
            end
            outR = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 31) == 0);
            applyStimulus(pendV, pIns, pOp, pTag, outR, fl, acc);
            if (acc) pendV = 1'b0;
        end

        applyStimulus(1'b1, 32'hFFF00093, 3'd0, 4'd1, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 32'h7FF00093, 3'd0, 4'd2, 1'b0, 1'b0, acc);
        checkOutput("preRstFull", 64'(busA.inReady), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        modelQ.delete();
        modelErr = 0;
        checkState();
        checkOutput("rstMidValid", 64'(busA.outValid), 64'd0);
        checkOutput("rstMidSout",  busB.sOut,          64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 32'h00A00093, 3'd0, 4'd5, 1'b0, 1'b0, acc);
        checkOutput("postRstSout", 64'(busA.sOut),   64'd10);
        checkOutput("postRstTag",  64'(busA.outTag), 64'd5);
        idleDrain();

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
